codec_intf: RTL and testbench

- I2S master interface between the external audio codec and the digital equalizer core.
- Generates the codec clocks MCLK, SCLK and LRCLK and the codec reset RSTn.
- Deserializes SDout into 16-bit signed lft_in/rht_in with a one-cycle valid strobe per frame.
- Serializes the core's lft_out/rht_out onto SDin.

---
 rtl/codec_pkg.sv | 20 ++
 rtl/codec_intf_if.sv | 27 ++
 rtl/codec_intf.sv | 111 +++++++++++
 tb/tb_codec_intf.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared constants and sample type for the I2S codec interface (10-bit frame counter, 16-bit samples).
package codec_pkg;

  localparam int SMPL_W = 16;

  // Data slots within one LRCLK half: MSB in slot 1, LSB in slot 16.
  localparam logic [4:0] MSB_SLOT = 5'd1;
  localparam logic [4:0] LSB_SLOT = 5'd16;

  // Counter values on which the last bit of each channel is sampled.
  localparam int L_DONE = 263;
  localparam int R_DONE = 775;

  typedef logic signed [SMPL_W-1:0] smpl_t;

  function automatic logic slot_in_word(input logic [4:0] s);
    return (s >= MSB_SLOT) && (s <= LSB_SLOT);
  endfunction

endpackage

// File: rtl/codec_intf_if.sv
// Pin bundle between codec, equalizer core and the I2S master; master modport is the codec_intf side.
interface codec_intf_if;
  import codec_pkg::*;

  logic  SDout;
  smpl_t lft_out;
  smpl_t rht_out;
  logic  MCLK;
  logic  SCLK;
  logic  LRCLK;
  logic  RSTn;
  logic  SDin;
  smpl_t lft_in;
  smpl_t rht_in;
  logic  valid;

  modport master (
    input  SDout, lft_out, rht_out,
    output MCLK, SCLK, LRCLK, RSTn, SDin, lft_in, rht_in, valid
  );

  modport slave (
    output SDout, lft_out, rht_out,
    input  MCLK, SCLK, LRCLK, RSTn, SDin, lft_in, rht_in, valid
  );

endinterface

// File: rtl/codec_intf.sv
// I2S master: codec clocks from one free-running counter, RX samples valid 1 clk after R LSB, TX loaded per half-frame; no backpressure.
// Define CODEC_LOOPBACK_EN to retransmit the received samples on SDin instead of lft_out/rht_out.
module codec_intf #(
  parameter int FRAME_W = 10,
  parameter int SMPL_W  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  codec_intf_if.master cif
);
  import codec_pkg::*;

  logic [FRAME_W-1:0] cnt;
  logic               rst_q;
  logic               frame_ok;
  logic [SMPL_W-1:0]  rx_shift;
  logic [SMPL_W-1:0]  rx_next;
  logic [SMPL_W-1:0]  lft_hold;
  logic [SMPL_W-1:0]  tx_shift;
  logic [SMPL_W-1:0]  tx_l_src;
  logic [SMPL_W-1:0]  tx_r_src;
  smpl_t              lft_q;
  smpl_t              rht_q;
  logic               valid_q;
  logic [4:0]         slot;
  logic               in_data;
  logic               rx_stb;
  logic               tx_stb;
  logic               wrap;
  logic               half;

  assign slot    = cnt[FRAME_W-2 -: 5];
  assign in_data = slot_in_word(slot);
  // Sample on the last clk before SCLK rises; shift TX on the last clk before SCLK falls.
  assign rx_stb  = in_data && (cnt[3:0] == 4'b0111);
  assign tx_stb  = in_data && (slot != LSB_SLOT) && (cnt[3:0] == 4'b1111);
  assign wrap    = &cnt;
  assign half    = (cnt == {1'b0, {(FRAME_W-1){1'b1}}});
  assign rx_next = {rx_shift[SMPL_W-2:0], cif.SDout};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      rst_q    <= 1'b0;
      frame_ok <= 1'b0;
    end else begin
      cnt   <= cnt + 1'b1;
      rst_q <= 1'b1;
      if (wrap) begin
        frame_ok <= 1'b1;
      end
    end
  end

  // Receive: the hold/output registers take rx_next so the LSB sampled this cycle is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift <= '0;
      lft_hold <= '0;
      lft_q    <= '0;
      rht_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rx_stb) begin
        rx_shift <= rx_next;
      end
      if (cnt == FRAME_W'(L_DONE)) begin
        lft_hold <= rx_next;
      end
      if (cnt == FRAME_W'(R_DONE)) begin
        lft_q   <= lft_hold;
        rht_q   <= rx_next;
        valid_q <= frame_ok;
      end
    end
  end

`ifdef CODEC_LOOPBACK_EN
  logic unused_core;
  assign tx_l_src    = lft_hold;
  assign tx_r_src    = rht_q;
  assign unused_core = ^{cif.lft_out, cif.rht_out};
`else
  assign tx_l_src = cif.lft_out;
  assign tx_r_src = cif.rht_out;
`endif

  // Transmit: core samples are captured only at the two half-frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
    end else if (wrap) begin
      tx_shift <= tx_l_src;
    end else if (half) begin
      tx_shift <= tx_r_src;
    end else if (tx_stb) begin
      tx_shift <= {tx_shift[SMPL_W-2:0], 1'b0};
    end
  end

  assign cif.MCLK   = cnt[1];
  assign cif.SCLK   = cnt[3];
  assign cif.LRCLK  = cnt[FRAME_W-1];
  assign cif.RSTn   = rst_q;
  assign cif.SDin   = in_data & tx_shift[SMPL_W-1];
  assign cif.lft_in = lft_q;
  assign cif.rht_in = rht_q;
  assign cif.valid  = valid_q;

endmodule

// File: tb/tb_codec_intf.sv
// Self-checking bench for codec_intf: I2S codec model on SDout, per-cycle clock/SDin checks, RX scoreboard.
module tb_codec_intf;
  import codec_pkg::*;

  typedef struct packed {
    smpl_t l;
    smpl_t r;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_valid = 0;

  codec_intf_if cif ();

  codec_intf #(.FRAME_W(10), .SMPL_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cif   (cif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model of the frame timing and of what the DUT should be sending/receiving.
  logic [9:0] m_cnt;
  logic       m_fok;
  smpl_t      m_lhold, m_rht, m_txl, m_txr;
  smpl_t      cod_l, cod_r;
  pair_t      sb[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= '0;
      m_fok   <= 1'b0;
      m_lhold <= '0;
      m_rht   <= '0;
      m_txl   <= '0;
      m_txr   <= '0;
      sb.delete();
    end else begin
      m_cnt <= m_cnt + 10'd1;
      if (m_cnt == 10'd1023) begin
        m_fok <= 1'b1;
`ifdef CODEC_LOOPBACK_EN
        m_txl <= m_lhold;
`else
        m_txl <= cif.lft_out;
`endif
      end
      if (m_cnt == 10'd511) begin
`ifdef CODEC_LOOPBACK_EN
        m_txr <= m_rht;
`else
        m_txr <= cif.rht_out;
`endif
      end
      if (m_cnt == 10'd263) m_lhold <= cod_l;
      if (m_cnt == 10'd775) begin
        m_rht <= cod_r;
        if (m_fok) sb.push_back('{l: m_lhold, r: cod_r});
      end
    end
  end

  // Codec ADC: MSB-first in slots 1..16 of each LRCLK half, driven away from the sampling edge.
  always @(negedge clk) begin : codec_tx
    logic [4:0] s;
    smpl_t      w;
    s = m_cnt[8:4];
    w = m_cnt[9] ? cod_r : cod_l;
    if (s >= 5'd1 && s <= 5'd16) cif.SDout = w[16-s];
    else                         cif.SDout = 1'b0;
  end

  always @(negedge clk) begin : monitor
    logic [4:0] s;
    smpl_t      w;
    logic       e_sd;
    pair_t      p;
    if (rst_n) begin
      chk("mclk",  32'(cif.MCLK),  32'(m_cnt[1]));
      chk("sclk",  32'(cif.SCLK),  32'(m_cnt[3]));
      chk("lrclk", 32'(cif.LRCLK), 32'(m_cnt[9]));
      chk("rstn",  32'(cif.RSTn),  32'd1);
      s    = m_cnt[8:4];
      w    = m_cnt[9] ? m_txr : m_txl;
      e_sd = (s >= 5'd1 && s <= 5'd16) ? w[16-s] : 1'b0;
      chk("sdin",  32'(cif.SDin),  32'(e_sd));
      chk("valid", 32'(cif.valid), 32'(m_fok && (m_cnt == 10'd776)));
      if (cif.valid) begin
        n_valid++;
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          p = sb.pop_front();
          chk("lft_in", 32'(cif.lft_in), 32'(p.l));
          chk("rht_in", 32'(cif.rht_in), 32'(p.r));
        end
      end
    end
  end

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (m_cnt == 10'(v)) return;
    end
    chk("wait_cnt", 32'(m_cnt), 32'(v));
  endtask

  smpl_t pat_l [3];
  smpl_t pat_r [3];
  int    snap;

  initial begin
    pat_l[0] = 16'h7FFF; pat_r[0] = 16'h8000;
    pat_l[1] = 16'hFFFF; pat_r[1] = 16'h0001;
    pat_l[2] = 16'h1234; pat_r[2] = 16'hCDEF;
`ifdef CODEC_LOOPBACK_EN
    cod_l = 16'h0001;
    cod_r = 16'hFFFF;
`else
    cod_l = 16'h8001;
    cod_r = 16'h7FFE;
`endif
    cif.lft_out = 16'hA5C3;
    cif.rht_out = 16'h0F0F;

    repeat (20) @(posedge clk);
    #1;
    chk("rst_sdin",  32'(cif.SDin),   32'd0);
    chk("rst_valid", 32'(cif.valid),  32'd0);
    chk("rst_lft",   32'(cif.lft_in), 32'd0);
    chk("rst_rht",   32'(cif.rht_in), 32'd0);
    chk("rst_rstn",  32'(cif.RSTn),   32'd0);
    chk("rst_mclk",  32'(cif.MCLK),   32'd0);
    chk("rst_sclk",  32'(cif.SCLK),   32'd0);
    chk("rst_lrclk", 32'(cif.LRCLK),  32'd0);

    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rstn_before_edge", 32'(cif.RSTn), 32'd0);
    @(posedge clk);
    #1 chk("rstn_after_edge", 32'(cif.RSTn), 32'd1);

    // Frames 1 and 2: valid suppressed in the first, exactly one pulse in the second.
    wait_cnt(1000);
    chk("valid_frame1", 32'(n_valid), 32'd0);
    wait_cnt(1000);
    chk("valid_frame2", 32'(n_valid), 32'd1);

    for (int k = 0; k < 3; k++) begin
      wait_cnt(0);
      cod_l = pat_l[k];
      cod_r = pat_r[k];
      wait_cnt(1000);
    end
    chk("valid_after_patterns", 32'(n_valid), 32'd4);

    // Core input changed mid-frame: the word latched at the frame boundary keeps going out.
    wait_cnt(1020);
    cif.lft_out = 16'h1234;
    wait_cnt(100);
    cif.lft_out = 16'h4321;
    wait_cnt(1000);
    wait_cnt(1000);

    wait_cnt(600);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(cif.valid),  32'd0);
    chk("mid_rst_sdin",  32'(cif.SDin),   32'd0);
    chk("mid_rst_rstn",  32'(cif.RSTn),   32'd0);
    chk("mid_rst_lft",   32'(cif.lft_in), 32'd0);
    chk("mid_rst_lrclk", 32'(cif.LRCLK),  32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    snap = n_valid;
    wait_cnt(1000);
    chk("valid_supp_after_rst", 32'(n_valid - snap), 32'd0);
    wait_cnt(1000);
    chk("valid_resume_after_rst", 32'(n_valid - snap), 32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
